// File: rtl/invsqrt_pkg.sv
// Shared types and constants for the inverse-square-root Newton-Raphson engine.
package invsqrt_pkg;

    // Positive single-precision float with the sign bit dropped.
    typedef logic [30:0] fp31_t;

    // Controller states: one issue/wait state per datapath step.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SQ   = 3'd1,
        ST_HX   = 3'd2,
        ST_SUB  = 3'd3,
        ST_UPD  = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    // Magic constant for the bit-trick initial estimate.
    localparam logic [31:0] C_MAGIC    = 32'h5F3759DF;
    // +infinity with the sign bit dropped.
    localparam fp31_t       C_INF31    = 31'h7F800000;
    // 1.5, the constant the external subtractor takes a away from.
    localparam fp31_t       C_ONE_HALF = 31'h3FC00000;

endpackage

// File: rtl/invsqrt_seed.sv
// Combinational seed generation: first estimate y0 and the halved operand x/2.
module invsqrt_seed
    import invsqrt_pkg::*;
(
    input  fp31_t x_i,
    output fp31_t y0_o,
    output fp31_t xh_o
);

    logic [7:0]  exp_w;
    logic [22:0] mant_w;

    assign exp_w  = x_i[30:23];
    assign mant_w = x_i[22:0];

    // Magic-constant estimate; the top bit of the 32-bit difference is the dropped sign.
    assign y0_o = 31'(C_MAGIC - ({1'b0, x_i} >> 1));

    // Halve x: decrement the exponent, or shift into the subnormal range at the bottom.
    always_comb begin
        if (exp_w >= 8'd2) begin
            xh_o = {exp_w - 8'd1, mant_w};
        end else begin
            xh_o = {8'h00, exp_w[0], mant_w[22:1]};
        end
    end

endmodule

// File: rtl/invsqrt_nr_ctrl.sv
// Newton-Raphson sequencer for 1/sqrt(x): drives an external pipelined multiplier
// and a (1.5 - a) subtractor through NR_ITER refinement steps.
// Optional macro INVSQRT_SPECIAL_EN: zero/denormal, infinity and NaN inputs bypass
// the iterations and return their fixed result one cycle after acceptance.
// Handshake: a transfer happens on a rising edge where in_valid and in_ready are
// both high; in_ready is high only in IDLE with ce high and reset released.
// mul_valid/sub_valid/out_valid are single-cycle strobes, all suppressed while ce=0.
module invsqrt_nr_ctrl
    import invsqrt_pkg::*;
#(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned SUB_LAT = 3,
    parameter int unsigned NR_ITER = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [30:0] in_data,
    output logic        mul_valid,
    output logic [30:0] mul_a,
    output logic [30:0] mul_b,
    input  logic [30:0] mul_y,
    output logic        sub_valid,
    output logic [30:0] sub_a,
    input  logic [30:0] sub_y,
    output logic        out_valid,
    output logic [30:0] out_data
);

    localparam int CW = 8;
    localparam logic [CW-1:0] MUL_END  = CW'(MUL_LAT);
    localparam logic [CW-1:0] SUB_END  = CW'(SUB_LAT);
    localparam logic [2:0]    ITER_END = 3'(NR_ITER);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    it_q, it_d;
    fp31_t         xh_q, xh_d;
    fp31_t         y_q, y_d;
    fp31_t         tmp_q, tmp_d;
    fp31_t         out_q, out_d;
    fp31_t         seed_y0, seed_xh;

    invsqrt_seed u_seed (
        .x_i  (in_data),
        .y0_o (seed_y0),
        .xh_o (seed_xh)
    );

`ifdef INVSQRT_SPECIAL_EN
    logic  special;
    fp31_t special_val;

    // Classify inputs whose result is fixed and needs no iteration.
    always_comb begin
        special     = 1'b0;
        special_val = '0;
        if (in_data[30:23] == 8'h00) begin
            special     = 1'b1;
            special_val = C_INF31;
        end else if (in_data[30:23] == 8'hFF) begin
            special     = 1'b1;
            special_val = (in_data[22:0] == 23'd0) ? fp31_t'(0) : in_data;
        end
    end
`endif

    // State and datapath registers; everything holds while ce is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            it_q    <= '0;
            xh_q    <= '0;
            y_q     <= '0;
            tmp_q   <= '0;
            out_q   <= '0;
        end else if (ce) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            it_q    <= it_d;
            xh_q    <= xh_d;
            y_q     <= y_d;
            tmp_q   <= tmp_d;
            out_q   <= out_d;
        end
    end

    // Next state: each step waits for its unit latency, captures, then moves on.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        it_d    = it_q;
        xh_d    = xh_q;
        y_d     = y_q;
        tmp_d   = tmp_q;
        out_d   = out_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    xh_d    = seed_xh;
                    y_d     = seed_y0;
                    it_d    = '0;
                    cnt_d   = '0;
                    state_d = ST_SQ;
`ifdef INVSQRT_SPECIAL_EN
                    if (special) begin
                        out_d   = special_val;
                        state_d = ST_DONE;
                    end
`endif
                end
            end
            ST_SQ, ST_HX: begin
                if (cnt_q == MUL_END) begin
                    tmp_d   = mul_y;
                    cnt_d   = '0;
                    state_d = (state_q == ST_SQ) ? ST_HX : ST_SUB;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SUB: begin
                if (cnt_q == SUB_END) begin
                    tmp_d   = sub_y;
                    cnt_d   = '0;
                    state_d = ST_UPD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_UPD: begin
                if (cnt_q == MUL_END) begin
                    y_d   = mul_y;
                    it_d  = it_q + 3'd1;
                    cnt_d = '0;
                    if (it_q + 3'd1 < ITER_END) begin
                        state_d = ST_SQ;
                    end else begin
                        out_d   = mul_y;
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: operand muxing per state, strobes only on the first ce-enabled cycle.
    always_comb begin
        in_ready  = 1'b0;
        mul_valid = 1'b0;
        sub_valid = 1'b0;
        out_valid = 1'b0;
        mul_a     = '0;
        mul_b     = '0;
        sub_a     = '0;
        case (state_q)
            ST_IDLE: in_ready = ce & rst_n;
            ST_SQ: begin
                mul_valid = ce && (cnt_q == '0);
                mul_a     = y_q;
                mul_b     = y_q;
            end
            ST_HX: begin
                mul_valid = ce && (cnt_q == '0);
                mul_a     = xh_q;
                mul_b     = tmp_q;
            end
            ST_SUB: begin
                sub_valid = ce && (cnt_q == '0);
                sub_a     = tmp_q;
            end
            ST_UPD: begin
                mul_valid = ce && (cnt_q == '0);
                mul_a     = y_q;
                mul_b     = tmp_q;
            end
            ST_DONE: out_valid = ce;
            default: ;
        endcase
    end

    assign out_data = out_q;

endmodule

// File: tb/tb_invsqrt_nr_ctrl.sv
// Self-checking bench for invsqrt_nr_ctrl with behavioural multiplier/subtractor
// pipelines. Instance dut: default parameters. Instance dut_b: NR_ITER=1, MUL_LAT=2,
// SUB_LAT=1. Special-value cases run only when INVSQRT_SPECIAL_EN is defined.
module tb_invsqrt_nr_ctrl;

    localparam int MLA = 4;
    localparam int SLA = 3;
    localparam int MLB = 2;
    localparam int SLB = 1;

    logic        clk = 1'b0;
    logic        rst_n, ce;
    logic        in_valid, in_ready, mul_valid, sub_valid, out_valid;
    logic [30:0] in_data, mul_a, mul_b, mul_y, sub_a, sub_y, out_data;
    logic        in_valid_b, in_ready_b, mul_valid_b, sub_valid_b, out_valid_b;
    logic [30:0] in_data_b, mul_a_b, mul_b_b, mul_y_b, sub_a_b, sub_y_b, out_data_b;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int mul_cnt = 0, sub_cnt = 0, mulb_cnt = 0, subb_cnt = 0;
    int last_out = -100;

    // Scoreboard: expected result plus its tolerance, accept cycle and latency.
    logic [30:0] exp_q[$];
    real         rtol_q[$];
    int          acc_q[$];
    int          lat_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- DUTs ----------------
    invsqrt_nr_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y),
        .sub_valid(sub_valid), .sub_a(sub_a), .sub_y(sub_y),
        .out_valid(out_valid), .out_data(out_data)
    );

    invsqrt_nr_ctrl #(.MUL_LAT(MLB), .SUB_LAT(SLB), .NR_ITER(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .mul_valid(mul_valid_b), .mul_a(mul_a_b), .mul_b(mul_b_b), .mul_y(mul_y_b),
        .sub_valid(sub_valid_b), .sub_a(sub_a_b), .sub_y(sub_y_b),
        .out_valid(out_valid_b), .out_data(out_data_b)
    );

    // ---------------- float helpers ----------------
    function automatic real f2r(input logic [30:0] f);
        logic [63:0] b;
        if (f[30:23] == 8'h00) return 0.0;
        b = {1'b0, 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(b);
    endfunction

    function automatic logic [30:0] r2f(input real r);
        logic [63:0] b;
        int          e;
        logic [30:0] m;
        if (r <= 0.0) return '0;
        b = $realtobits(r);
        e = int'(b[62:52]) - 896;
        if (e <= 0) return '0;
        if (e >= 255) return 31'h7F800000;
        m = {e[7:0], b[51:29]};
        if (b[28]) m = m + 31'd1;
        return m;
    endfunction

    function automatic logic [30:0] ref_isqrt(input logic [30:0] x);
        return r2f(1.0 / $sqrt(f2r(x)));
    endfunction

    // ---------------- behavioural datapath units ----------------
    logic [30:0] ma_pipe[MLA];
    logic [30:0] sa_pipe[SLA];
    logic [30:0] mb_pipe[MLB];
    logic [30:0] sb_pipe[SLB];

    always @(posedge clk) begin
        if (ce) begin
            ma_pipe[0] <= r2f(f2r(mul_a) * f2r(mul_b));
            for (int i = 1; i < MLA; i++) ma_pipe[i] <= ma_pipe[i-1];
            sa_pipe[0] <= r2f(1.5 - f2r(sub_a));
            for (int i = 1; i < SLA; i++) sa_pipe[i] <= sa_pipe[i-1];
            mb_pipe[0] <= r2f(f2r(mul_a_b) * f2r(mul_b_b));
            for (int i = 1; i < MLB; i++) mb_pipe[i] <= mb_pipe[i-1];
            sb_pipe[0] <= r2f(1.5 - f2r(sub_a_b));
        end
    end

    assign mul_y   = ma_pipe[MLA-1];
    assign sub_y   = sa_pipe[SLA-1];
    assign mul_y_b = mb_pipe[MLB-1];
    assign sub_y_b = sb_pipe[SLB-1];

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp,
                         input real rtol);
        bit  bad;
        real g, e, d;
        n_cmp++;
        if (rtol > 0.0) begin
            g   = f2r(got[30:0]);
            e   = f2r(exp[30:0]);
            d   = (g > e) ? g - e : e - g;
            bad = (d > rtol * e);
        end else begin
            bad = (got !== exp);
        end
        if (bad) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Monitor: pop the scoreboard on each result, count strobes, police ce=0 cycles.
    always @(negedge clk) begin
        #2;
        if (mul_valid) mul_cnt++;
        if (sub_valid) sub_cnt++;
        if (mul_valid_b) mulb_cnt++;
        if (sub_valid_b) subb_cnt++;
        if (!ce) begin
            check("ce_low_strobes", {28'd0, in_ready, mul_valid, sub_valid, out_valid}, 32'd0, 0.0);
            check("ce_low_strobes_b", {28'd0, in_ready_b, mul_valid_b, sub_valid_b, out_valid_b},
                  32'd0, 0.0);
        end
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'd1, 32'd0, 0.0);
            end else begin
                check("out_data", {1'b0, out_data}, {1'b0, exp_q.pop_front()}, rtol_q.pop_front());
                check("latency", 32'(cyc - acc_q.pop_front()), 32'(lat_q.pop_front()), 0.0);
            end
            last_out = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a falling edge; returns after the accepting rising edge.
    task automatic send(input logic [30:0] x, input logic [30:0] expv, input real rtol,
                        input int lat, input bit track, output int acc);
        int n = 0;
        in_valid = 1'b1;
        in_data  = x;
        acc      = -1;
        #1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'd0, 32'd1, 0.0);
            return;
        end
        acc = cyc;
        if (track) begin
            exp_q.push_back(expv);
            rtol_q.push_back(rtol);
            acc_q.push_back(acc);
            lat_q.push_back(lat);
        end
        @(negedge clk);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0, 0.0);
        repeat (2) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          acc;
        bit          got_b;
        int          outb_cyc;
        logic [30:0] outb_data;
        logic [30:0] x;

        rst_n      = 1'b0;
        ce         = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_valid_b = 1'b0;
        in_data_b  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_strobes", {28'd0, in_ready, mul_valid, sub_valid, out_valid}, 32'd0, 0.0);
        check("rst_out_data", {1'b0, out_data}, 32'd0, 0.0);
        check("rst_mul_ops", {1'b0, mul_a | mul_b | sub_a}, 32'd0, 0.0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", {31'd0, in_ready}, 32'd1, 0.0);
        @(negedge clk);

        // x = 4.0: latency 39, 6 multiplies and 2 subtracts
        mul_cnt = 0;
        sub_cnt = 0;
        send(31'h40800000, ref_isqrt(31'h40800000), 1e-4, 39, 1'b1, acc);
        in_valid = 1'b0;
        wait_drain(200);
        check("mul_pulses", 32'(mul_cnt), 32'd6, 0.0);
        check("sub_pulses", 32'(sub_cnt), 32'd2, 0.0);
        repeat (3) @(negedge clk);
        check("out_hold", {1'b0, out_data}, {1'b0, ref_isqrt(31'h40800000)}, 1e-4);

        // Ramp 0.40 .. 1.00 held back-to-back
        for (int i = 0; i <= 60; i++) begin
            x = r2f(0.40 + 0.01 * i);
            send(x, ref_isqrt(x), 1e-4, 39, 1'b1, acc);
            if (i > 0) check("b2b_accept", 32'(acc), 32'(last_out + 1), 0.0);
        end
        in_valid = 1'b0;
        wait_drain(200);

        // ce low for 5 cycles during the HX wait
        send(31'h40000000, ref_isqrt(31'h40000000), 1e-4, 44, 1'b1, acc);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        ce = 1'b0;
        repeat (5) @(negedge clk);
        ce = 1'b1;
        wait_drain(200);

        // Reset during UPD of iteration 1; the operand must vanish
        send(31'h40800000, '0, 0.0, 0, 1'b0, acc);
        in_valid = 1'b0;
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_strobes", {28'd0, in_ready, mul_valid, sub_valid, out_valid}, 32'd0, 0.0);
        check("midrst_out_data", {1'b0, out_data}, 32'd0, 0.0);
        check("midrst_ops", {1'b0, mul_a | mul_b | sub_a}, 32'd0, 0.0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_midrst", {31'd0, in_ready}, 32'd1, 0.0);
        @(negedge clk);
        send(31'h41100000, ref_isqrt(31'h41100000), 1e-4, 39, 1'b1, acc);
        in_valid = 1'b0;
        wait_drain(200);
        check("nine_third", {1'b0, out_data}, {1'b0, r2f(1.0 / 3.0)}, 1e-4);

`ifdef INVSQRT_SPECIAL_EN
        mul_cnt = 0;
        sub_cnt = 0;
        send(31'h00000000, 31'h7F800000, 0.0, 1, 1'b1, acc);
        send(31'h7F800000, 31'h00000000, 0.0, 1, 1'b1, acc);
        send(31'h7FC00000, 31'h7FC00000, 0.0, 1, 1'b1, acc);
        in_valid = 1'b0;
        wait_drain(50);
        check("special_mul_pulses", 32'(mul_cnt), 32'd0, 0.0);
        check("special_sub_pulses", 32'(sub_cnt), 32'd0, 0.0);
`endif

        // Second configuration: NR_ITER=1, MUL_LAT=2, SUB_LAT=1
        mulb_cnt   = 0;
        subb_cnt   = 0;
        in_valid_b = 1'b1;
        in_data_b  = 31'h40800000;
        #1;
        acc = cyc;
        check("b_ready", {31'd0, in_ready_b}, 32'd1, 0.0);
        @(negedge clk);
        in_valid_b = 1'b0;
        got_b      = 1'b0;
        outb_cyc   = 0;
        outb_data  = '0;
        for (int n = 0; n < 100 && !got_b; n++) begin
            @(negedge clk);
            #2;
            if (out_valid_b) begin
                got_b     = 1'b1;
                outb_cyc  = cyc;
                outb_data = out_data_b;
            end
        end
        check("b_out_seen", {31'd0, got_b}, 32'd1, 0.0);
        check("b_latency", 32'(outb_cyc - acc), 32'd12, 0.0);
        check("b_out_data", {1'b0, outb_data}, {1'b0, ref_isqrt(31'h40800000)}, 2e-3);
        check("b_mul_pulses", 32'(mulb_cnt), 32'd3, 0.0);
        check("b_sub_pulses", 32'(subb_cnt), 32'd1, 0.0);

        repeat (3) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0, 0.0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
